bsg_manycore_sdr_rx_token_fifo: RTL
===================================

// Module: bsg_manycore_sdr_rx_token_fifo
// PURPOSE
//   Receive end of the token-credited SDR link. Captures link words
//   (link_v_i/link_data_i), buffers them in a 2^lg_fifo_depth_p FIFO and
//   presents them to the core with a valid/yumi handshake.
//   Returns credits upstream as an edge-encoded token: one link_token_o
//   toggle per 2^lg_credit_to_token_decimation_p dequeued words.
//   Sits between the link capture flops and the manycore fwd/rev link_sif.
// PARAMETERS
//   width_p                          "inv"  payload width (fwd or rev packet width)
//   lg_fifo_depth_p                  3      log2 FIFO depth; must be >= 1
//   lg_credit_to_token_decimation_p  1      log2 dequeues per token; must be <= lg_fifo_depth_p
// PORTS
//   clk_i        in   1                  clock
//   reset_i      in   1                  asynchronous reset, active-high
//   link_v_i     in   1                  incoming word valid; no back-pressure
//   link_data_i  in   width_p            incoming word
//   core_v_o     out  1                  FIFO head valid
//   core_data_o  out  width_p            FIFO head data
//   core_yumi_i  in   1                  core consumes head; legal only when core_v_o=1
//   link_token_o out  1                  edge-encoded credit return (toggle = 2^D credits)
//   occupancy_o  out  lg_fifo_depth_p+1  current entry count, 0..2^lg_fifo_depth_p
//   overflow_o   out  1                  sticky overflow flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async assert, sync-safe deassert by caller):
//   - Clears read/write pointers, occupancy, credit counter and FIFO state.
//   - Outputs during and after reset: core_v_o=0, link_token_o=0, occupancy_o=0, overflow_o=0.
//   - core_data_o is don't-care while core_v_o=0.
//   - Reset mid-operation discards all buffered words and any partial credit count.
//   FIFO
//   - Registered storage with no input-to-output bypass.
//   - link_v_i in cycle n: core_v_o=1 with that word in cycle n+1, when the FIFO was empty.
//   - Head data is stable while core_v_o=1 and core_yumi_i=0. Strict FIFO order.
//   - core_v_o = (occupancy != 0).
//   - occupancy_o next = occ + enq - deq.
//   - enq = link_v_i & (not full | core_yumi_i).
//   - deq = core_yumi_i.
//   - Full with link_v_i and core_yumi_i together: the word is accepted, occupancy stays full, no overflow.
//   - Full with link_v_i and no core_yumi_i: the word is dropped, no state changes, overflow event.
//   - core_yumi_i while empty is illegal; the block ignores it (no pointer move, no credit).
//   - Pointers wrap modulo 2^lg_fifo_depth_p.
//   Credit / token
//   - D-bit credit counter (D = lg_credit_to_token_decimation_p) increments on each deq.
//   - When the counter wraps to 0, link_token_o toggles in the next cycle (registered).
//   - D=0: link_token_o toggles one cycle after every deq.
//   - link_token_o is driven directly from a flop (glitch-free for the pad).
//   - Only dequeues generate credit, never enqueues. Dropped words generate no credit.
// CONFIGURATION
//   BSG_MANYCORE_SDR_RX_OVERFLOW_CHECK_EN
//   - Defined: overflow_o sets on the first overflow event and stays set until reset_i.
//     The simulation build also issues $error with the cycle time.
//   - Undefined: overflow_o tied to 0; no check logic. Dropping behaviour is unchanged.
// TESTING (width_p=16, lg_fifo_depth_p=3, D=1 unless noted)
//   1. Assert reset_i mid-cycle, no clock edge -> core_v_o, link_token_o, occupancy_o, overflow_o all 0 immediately.
//   2. link_v_i=1, data 0x00A5 in cycle 1 -> core_v_o=1, core_data_o=0x00A5 in cycle 2;
//      yumi in cycle 3 -> core_v_o=0, occupancy 0 in cycle 4; token unchanged (1 of 2 credits).
//   3. Write 0x0001..0x0008 back-to-back, no yumi -> occupancy_o=8;
//      drain with continuous yumi -> data 1..8 in order, link_token_o toggles 4 times, each one cycle after the 2nd/4th/6th/8th yumi.
//   4. FIFO full (8), 20 cycles of simultaneous link_v_i+yumi with incrementing data
//      -> occupancy stays 8, output order preserved, overflow_o=0, 10 token toggles.
//   5. FIFO full, no yumi, 9th write 0xDEAD
//      -> with macro: overflow_o=1 next cycle and stays 1; drain returns the original 8 words, 0xDEAD absent.
//      -> without macro: same data, overflow_o=0.
//   6. Occupancy 5, credit counter 1, pulse reset_i -> all state cleared, link_token_o=0;
//      then 2 writes + 2 yumis -> exactly one token toggle.

Source files
------------

// File: rtl/bsg_manycore_sdr_rx_token_fifo.sv
// Receive side of the token-credited SDR link: word FIFO plus credit-token return.
// Optional sticky overflow detection is built with BSG_MANYCORE_SDR_RX_OVERFLOW_CHECK_EN.
module bsg_manycore_sdr_rx_token_fifo #(
  parameter int width_p                         = 16,
  parameter int lg_fifo_depth_p                 = 3,
  parameter int lg_credit_to_token_decimation_p = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       link_v_i,
  input  logic [width_p-1:0]         link_data_i,
  output logic                       core_v_o,
  output logic [width_p-1:0]         core_data_o,
  input  logic                       core_yumi_i,
  output logic                       link_token_o,
  output logic [lg_fifo_depth_p:0]   occupancy_o,
  output logic                       overflow_o
);

  localparam int depth_lp = 1 << lg_fifo_depth_p;
  localparam int dec_lp   = lg_credit_to_token_decimation_p;
  localparam int cw_lp    = (dec_lp > 0) ? dec_lp : 1;

  logic [width_p-1:0]         mem_q [depth_lp];
  logic [lg_fifo_depth_p-1:0] wptr_q, wptr_d;
  logic [lg_fifo_depth_p-1:0] rptr_q, rptr_d;
  logic [lg_fifo_depth_p:0]   occ_q, occ_d;
  logic [cw_lp-1:0]           cred_q, cred_d;
  logic                       token_q, token_d;

  logic full, empty, enq, deq, wrap;

  assign full  = (occ_q == (lg_fifo_depth_p+1)'(depth_lp));
  assign empty = (occ_q == '0);
  assign enq   = link_v_i & (~full | core_yumi_i);
  // a yumi on an empty FIFO is ignored outright
  assign deq   = core_yumi_i & ~empty;
  assign wrap  = deq & ((dec_lp == 0) || (cred_q == '1));

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    occ_d   = occ_q;
    cred_d  = cred_q;
    token_d = token_q ^ wrap;
    if (enq) wptr_d = wptr_q + 1'b1;
    if (deq) rptr_d = rptr_q + 1'b1;
    unique case ({enq, deq})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    if (deq) begin
      if (dec_lp == 0) cred_d = '0;
      else             cred_d = cred_q + cw_lp'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      cred_q  <= '0;
      token_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      cred_q  <= cred_d;
      token_q <= token_d;
    end
  end

  // storage needs no reset: occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= link_data_i;
  end

  assign core_v_o     = ~empty;
  assign core_data_o  = mem_q[rptr_q];
  assign link_token_o = token_q;
  assign occupancy_o  = occ_q;

`ifdef BSG_MANYCORE_SDR_RX_OVERFLOW_CHECK_EN
  logic ovf_evt, ovf_q;

  assign ovf_evt = link_v_i & full & ~core_yumi_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      ovf_q <= 1'b0;
    else if (ovf_evt) ovf_q <= 1'b1;
  end

  assign overflow_o = ovf_q;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i && ovf_evt)
      $error("sdr_rx_token_fifo overflow at time %0t", $time);
  end
`endif
`else
  assign overflow_o = 1'b0;
`endif

endmodule
